// File: rtl/mips_ifetch_queue_if.sv
// rtl/mips_ifetch_queue_if.sv - instruction memory, redirect and decode-side signals of the fetch queue
interface mips_ifetch_queue_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ir;
  logic [31:0]       out_npc;
  logic [CNT_W-1:0]  q_count;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, out_valid, out_ir, out_npc, q_count,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, out_ready
  );

  // memory / pipeline side
  modport slave (
    input  imem_req, imem_addr, out_valid, out_ir, out_npc, q_count,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/mips_ifetch_queue.sv
// rtl/mips_ifetch_queue.sv - MIPS32 instruction prefetch queue; optional same-cycle bypass via IFQ_BYPASS_EN
module mips_ifetch_queue #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input logic                 clk1,
  input logic                 rst_n,
  mips_ifetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [31:0]       ir_mem_q  [DEPTH];
  logic [31:0]       npc_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       hold_ir_q, hold_npc_q;

  logic        head_valid;
  logic        resp_ok;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] resp_npc;

  assign head_valid = (count_q != '0);
  // Response is kept only when no flush is pending or happening this cycle.
  assign resp_ok    = (state_q == S_WAIT) && bus.imem_rvalid && !drop_q && !bus.redirect_valid;
  assign resp_npc   = 32'(addr_q) + 32'd1;
  assign pop        = head_valid && bus.out_ready;
  assign push       = resp_ok && !(bypass && bus.out_ready);

  assign bus.imem_addr = pc_q;
  assign bus.q_count   = count_q;

  // Head of queue to decode; bypass only when the queue is empty.
  always_comb begin
    bypass        = 1'b0;
    bus.out_valid = head_valid;
    bus.out_ir    = hold_ir_q;
    bus.out_npc   = hold_npc_q;
    if (head_valid) begin
      bus.out_ir  = ir_mem_q[rd_ptr_q];
      bus.out_npc = npc_mem_q[rd_ptr_q];
    end
`ifdef IFQ_BYPASS_EN
    else if (resp_ok) begin
      bypass        = 1'b1;
      bus.out_valid = 1'b1;
      bus.out_ir    = bus.imem_rdata;
      bus.out_npc   = resp_npc;
    end
`endif
  end

  // Fetch FSM next state: one request outstanding, a slot reserved per request.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    bus.imem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.halt && (count_q < CNT_W'(DEPTH))) state_d = S_REQ;
      end
      S_REQ: begin
        bus.imem_req = 1'b1;
        if (bus.imem_gnt) begin
          addr_d  = pc_q;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A redirect wins over sequential PC; an in-flight word becomes stale.
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      if (((state_q == S_REQ) && bus.imem_gnt) || ((state_q == S_WAIT) && !bus.imem_rvalid))
        drop_d = 1'b1;
    end
  end

  // Fetch FSM state registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // Circular buffer pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem_q[wr_ptr_q]  <= bus.imem_rdata;
      npc_mem_q[wr_ptr_q] <= resp_npc;
    end
  end

  // Last presented head, shown while the queue is empty.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      hold_ir_q  <= '0;
      hold_npc_q <= '0;
    end else if (bus.out_valid) begin
      hold_ir_q  <= bus.out_ir;
      hold_npc_q <= bus.out_npc;
    end
  end
endmodule

// File: tb/tb_mips_ifetch_queue.sv
// tb/tb_mips_ifetch_queue.sv - scoreboard bench for the instruction prefetch queue
module tb_mips_ifetch_queue;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  mips_ifetch_queue_if #(.ADDR_W(10), .DEPTH(4)) bus ();

  mips_ifetch_queue #(.ADDR_W(10), .DEPTH(4), .RESET_PC(0)) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  int          n_vec = 0;
  int          n_err = 0;
  ent_t        exp_q[$];
  logic [31:0] hist_ir[$];
  logic [31:0] hist_npc[$];
  logic        pend = 1'b0;
  logic [9:0]  pend_addr = '0;
  logic        drop_m = 1'b0;
  int          wait_cnt = 0;
  int          gnt_delay = 0;
  int          gnt_cnt = 0;
  int          push_cnt = 0;
  int          seen_dead = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    case (a)
      10'd0:   mem_word = 32'h2801_0005;
      10'd1:   mem_word = 32'h2802_0007;
      10'd2:   mem_word = 32'h0022_1800;
      10'd3:   mem_word = 32'hFC00_0000;
      default: mem_word = {16'hC0DE, 6'd0, a};
    endcase
  endfunction

  // memory model: grant after gnt_delay cycles of request, respond the cycle after grant
  task automatic mem_drive();
    bus.imem_gnt    = bus.imem_req && (wait_cnt >= gnt_delay);
    bus.imem_rvalid = pend;
    bus.imem_rdata  = pend ? mem_word(pend_addr) : 32'h0;
  endtask

  // observe the completed cycle just before its closing edge
  task automatic monitor();
    logic pend_before;
    ent_t e;
    pend_before = pend;
    if (bus.imem_rvalid) begin
      if (!drop_m && !bus.redirect_valid) begin
        check("nofull", 64'(bus.q_count < 4), 64'd1);
        exp_q.push_back({bus.imem_rdata, 32'(pend_addr) + 32'd1});
        push_cnt++;
      end
      drop_m = 1'b0;
      pend   = 1'b0;
    end
    if (bus.imem_req && bus.imem_gnt) begin
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
      gnt_cnt++;
      wait_cnt  = 0;
      if (bus.redirect_valid) drop_m = 1'b1;
    end else if (bus.imem_req) begin
      wait_cnt++;
    end
    if (bus.redirect_valid && pend_before && !bus.imem_rvalid) drop_m = 1'b1;
    if (bus.out_valid && bus.out_ir == 32'hDEAD_BEEF) seen_dead++;
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      hist_ir.push_back(bus.out_ir);
      hist_npc.push_back(bus.out_npc);
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_ir", 64'(bus.out_ir), 64'(e.ir));
        check("sb_npc", 64'(bus.out_npc), 64'(e.npc));
      end
    end
    if (bus.redirect_valid) exp_q.delete();
  endtask

  task automatic tick();
    @(negedge clk1);
    monitor();
    @(posedge clk1);
    #1;
    mem_drive();
  endtask

  initial begin
    int k;
    int a0;
    int p0;
    int g0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    bus.out_ready      = 1'b1;

    repeat (3) @(posedge clk1);
    #1;
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.q_count), 64'd0);
    check("rst_ir", 64'(bus.out_ir), 64'd0);
    check("rst_npc", 64'(bus.out_npc), 64'd0);
    rst_n = 1'b1;
    mem_drive();

    // in-order delivery of the first four words
    for (int i = 0; i < 200 && hist_ir.size() < 4; i++) tick();
    check("t1_timeout", 64'(hist_ir.size() >= 4), 64'd1);
    if (hist_ir.size() >= 4) begin
      check("t1_ir0", 64'(hist_ir[0]), 64'h2801_0005);
      check("t1_ir1", 64'(hist_ir[1]), 64'h2802_0007);
      check("t1_ir2", 64'(hist_ir[2]), 64'h0022_1800);
      check("t1_ir3", 64'(hist_ir[3]), 64'hFC00_0000);
      for (int i = 0; i < 4; i++) check("t1_npc", 64'(hist_npc[i]), 64'(i + 1));
    end

    // back-pressure: fill to DEPTH, stop fetching, then drain without loss
    bus.out_ready = 1'b0;
    repeat (20) tick();
    check("t2_full", 64'(bus.q_count), 64'd4);
    for (int i = 0; i < 5; i++) begin
      check("t2_noreq", 64'(bus.imem_req), 64'd0);
      tick();
    end
    k = hist_ir.size();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && hist_ir.size() < k + 4; i++) tick();
    check("t2_timeout", 64'(hist_ir.size() >= k + 4), 64'd1);
    if (hist_ir.size() >= k + 4)
      for (int i = 1; i < 4; i++) check("t2_order", 64'(hist_npc[k+i]), 64'(hist_npc[k] + i));

    // redirect in WAIT with a same-cycle response that must be dropped
    for (int i = 0; i < 50 && !bus.imem_rvalid; i++) tick();
    check("t3_timeout", 64'(bus.imem_rvalid), 64'd1);
    bus.imem_rdata     = 32'hDEAD_BEEF;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h040;
    bus.out_ready      = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    k = hist_ir.size();
    for (int i = 0; i < 100 && hist_ir.size() <= k; i++) tick();
    check("t3_timeout2", 64'(hist_ir.size() > k), 64'd1);
    if (hist_ir.size() > k) begin
      check("t3_ir", 64'(hist_ir[k]), 64'(mem_word(10'h040)));
      check("t3_npc", 64'(hist_npc[k]), 64'h41);
    end

    // slow grant: address held, exactly one push
    gnt_delay = 5;
    tick();
    for (int i = 0; i < 50 && !(bus.imem_req && wait_cnt == 0); i++) tick();
    check("t4_timeout", 64'(bus.imem_req), 64'd1);
    bus.halt = 1'b1;
    a0 = int'(bus.imem_addr);
    p0 = push_cnt;
    for (int i = 0; i < 5; i++) begin
      check("t4_req", 64'(bus.imem_req), 64'd1);
      check("t4_addr", 64'(bus.imem_addr), 64'(a0));
      check("t4_nognt", 64'(bus.imem_gnt), 64'd0);
      tick();
    end
    repeat (8) tick();
    check("t4_pushes", 64'(push_cnt - p0), 64'd1);
    gnt_delay = 0;

    // halt with two entries queued and one request in flight
    repeat (5) tick();
    bus.halt      = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100 && !(bus.q_count == 2 && bus.imem_req); i++) tick();
    check("t5_timeout", 64'(bus.q_count == 2 && bus.imem_req), 64'd1);
    bus.halt = 1'b1;
    g0 = gnt_cnt;
    repeat (10) tick();
    check("t5_count", 64'(bus.q_count), 64'd3);
    check("t5_noreq", 64'(bus.imem_req), 64'd0);
    check("t5_grants", 64'(gnt_cnt - g0), 64'd1);
    k = hist_ir.size();
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("t5_drained", 64'(hist_ir.size() - k), 64'd3);
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_noreq2", 64'(bus.imem_req), 64'd0);
    bus.halt = 1'b0;

    // redirect in REQ before grant switches the address
    gnt_delay = 3;
    tick();
    for (int i = 0; i < 50 && !(bus.imem_req && wait_cnt == 0); i++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h100;
    bus.out_ready      = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    check("t7_req", 64'(bus.imem_req), 64'd1);
    check("t7_addr", 64'(bus.imem_addr), 64'h100);
    gnt_delay = 0;
    k = hist_ir.size();
    for (int i = 0; i < 100 && hist_ir.size() <= k; i++) tick();
    check("t7_timeout", 64'(hist_ir.size() > k), 64'd1);
    if (hist_ir.size() > k) begin
      check("t7_ir", 64'(hist_ir[k]), 64'(mem_word(10'h100)));
      check("t7_npc", 64'(hist_npc[k]), 64'h101);
    end

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h3FF;
    bus.out_ready      = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    k = hist_ir.size();
    for (int i = 0; i < 100 && hist_ir.size() < k + 2; i++) tick();
    check("t6_timeout", 64'(hist_ir.size() >= k + 2), 64'd1);
    if (hist_ir.size() >= k + 2) begin
      check("t6_ir0", 64'(hist_ir[k]), 64'(mem_word(10'h3FF)));
      check("t6_npc0", 64'(hist_npc[k]), 64'h400);
      check("t6_ir1", 64'(hist_ir[k+1]), 64'(mem_word(10'h000)));
      check("t6_npc1", 64'(hist_npc[k+1]), 64'h1);
    end

    repeat (5) tick();
    check("no_dead", 64'(seen_dead), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_ifetch_queue.md
Name: mips_ifetch_queue

Overview:
- Instruction fetch unit with a prefetch queue. It sits directly upstream of the decode stage of the 5-stage MIPS32 pipeline and replaces direct Mem[PC] reads in IF.
- It issues word-addressed requests to the instruction memory and buffers returned words with their next-PC value (PC+1).
- It supplies decode through a valid/ready handshake.
- Branch redirects from EX/MEM flush the queue. HALT stops further prefetching.

Parameters:
- ADDR_W, 10, word-address width (1024-word memory).
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk1  in  1  single clock; all logic on posedge clk1.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  word address of the request.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  taken-branch redirect, one-cycle pulse.
- redirect_pc  in  ADDR_W  branch target address.
- halt  in  1  level; stop issuing new fetches.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_ir  out  32  head instruction.
- out_npc  out  32  head address+1, zero-extended.
- q_count  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC; queue empty.
  - imem_req=0, out_valid=0, q_count=0, out_ir=0, out_npc=0.
  - FSM=IDLE; drop flag=0.
- FSM has three states: IDLE, REQ, WAIT. At most one request is outstanding.
  - IDLE -> REQ when halt=0 and (q_count + pending) < DEPTH. Pending is 0 in IDLE.
  - REQ: imem_req=1 and imem_addr=PC; both are held stable until imem_gnt. On gnt: PC<=PC+1 (wraps mod 2^ADDR_W), go to WAIT.
  - WAIT: on imem_rvalid, push {rdata, addr+1} unless drop=1, clear drop, go to IDLE. The next request may issue on the following cycle.
- Queue is a circular buffer.
  - Push and pop in the same cycle when full: pop first, push accepted, count unchanged.
  - Push when full cannot occur; the issue rule reserves a slot. The bench asserts this.
  - Pop when empty is ignored.
  - Pop occurs when out_valid && out_ready.
- Redirect (highest priority):
  - Queue is flushed: count<=0, out_valid<=0 next cycle. Any same-cycle push and pop are discarded.
  - PC<=redirect_pc.
  - In REQ before gnt: imem_addr switches to redirect_pc next cycle. This is the one legal exception to address stability; the memory must tolerate it.
  - In REQ with gnt in the same cycle: drop<=1, go to WAIT.
  - In WAIT: drop<=1. A response arriving in the same cycle as the redirect is dropped.
  - The first instruction fetched after a redirect is redirect_pc.
- halt:
  - Blocks IDLE->REQ only. A request already in REQ or WAIT completes.
  - The queue keeps draining to decode.
  - A redirect while halted still flushes the queue and loads PC.
- out_ir and out_npc reflect the head entry whenever out_valid=1; otherwise they hold their last value.
- Latency, without bypass: a response in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one instruction per 3 cycles with single-cycle gnt/rvalid (REQ, WAIT, IDLE).

Optional Feature:
- IFQ_BYPASS_EN, when defined:
  - If the queue is empty, imem_rvalid=1, drop=0 and no redirect is present: out_valid=1 in the same cycle, with out_ir=imem_rdata and out_npc=addr+1 combinationally.
  - If out_ready=1, the word is consumed and not pushed. Otherwise it is pushed normally.
- Undefined: no combinational path from imem_rdata to outputs; behaviour as above.

Test Plan:
- Reset with Mem[0..3]=0x28010005, 0x28020007, 0x00221800, 0xFC000000 and out_ready=1 -> out_ir sequence matches in order, with out_npc=1,2,3,4.
- Hold out_ready=0 for 20 cycles -> q_count saturates at 4; imem_req stays 0 after the 4th grant completes. Release out_ready -> the next 4 words are delivered in order, none lost.
- Redirect to 0x040 while in WAIT, with rvalid in the same cycle returning word 0xDEADBEEF -> 0xDEADBEEF is never output; the next out_ir is Mem[0x040] with out_npc=0x41.
- imem_gnt delayed 5 cycles during REQ -> imem_addr is stable for all 5 cycles; exactly one push occurs.
- halt=1 mid-stream with 2 entries queued -> no new imem_req after the in-flight request completes; 3 instructions drain; out_valid=0 thereafter.
- PC=0x3FF -> the fetch after 0x3FF goes to address 0x000; out_npc for that entry is 0x400.
